// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: weight-load, pixel-in and result-out signals of conv3x3_stream
interface conv3x3_stream_if #(parameter int DATA_W = 16, N_KERN = 3);
  logic load_start, w_valid, load_done, frame_start, in_valid, out_valid, frame_done, busy;
  logic signed [DATA_W-1:0] w_data, in_data;
  logic [N_KERN*DATA_W-1:0] out_data;
  modport master (
    output load_start, w_valid, w_data, frame_start, in_valid, in_data,
    input  load_done, out_valid, out_data, frame_done, busy
  );
  modport slave (
    input  load_start, w_valid, w_data, frame_start, in_valid, in_data,
    output load_done, out_valid, out_data, frame_done, busy
  );
endinterface

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-mode convolution with N_KERN runtime-loaded kernels.
// Define CONV_RELU_EN to clamp each saturated result at zero.
module conv3x3_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int N_KERN = 3,
  parameter int SHIFT  = 8
) (
  input logic clk,
  input logic RESET,
  conv3x3_stream_if.slave bus
);
  localparam int NW  = 9 * N_KERN;
  localparam int PW  = 2 * DATA_W;
  localparam int AW  = 2 * DATA_W + 4;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int WCW = $clog2(NW);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic w_loaded, drain_cnt, w_wr, px_acc, last_w, last_px, col_end, v1, l1;
  logic [WCW-1:0] wcnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [DATA_W-1:0] wt [NW];
  logic signed [DATA_W-1:0] lb1 [IMG_W];
  logic signed [DATA_W-1:0] lb2 [IMG_W];
  logic signed [DATA_W-1:0] win [9];
  logic signed [DATA_W-1:0] nwin [9];
  logic signed [PW-1:0] prod [N_KERN][9];
  logic signed [AW-1:0] acc [N_KERN];
  logic signed [AW-1:0] sh [N_KERN];
  logic signed [DATA_W-1:0] sat [N_KERN];
  logic [N_KERN*DATA_W-1:0] res, out_q;
  logic out_valid_q, frame_done_q, load_done_q;
  assign last_w  = wcnt == WCW'(NW - 1);
  assign col_end = col == CW'(IMG_W - 1);
  assign last_px = col_end && row == RW'(IMG_H - 1);
  assign bus.busy       = state_q == LOAD_W || state_q == RUN;
  assign bus.load_done  = load_done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_data   = out_q;
  always_ff @(posedge clk)
    if (RESET) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    w_wr = 1'b0;
    px_acc = 1'b0;
    case (state_q)
      IDLE:   state_d = bus.load_start ? LOAD_W : (bus.frame_start && w_loaded) ? RUN : IDLE;
      LOAD_W: begin
        w_wr = bus.w_valid;
        state_d = (bus.w_valid && last_w) ? IDLE : LOAD_W;
      end
      RUN: begin
        px_acc = bus.in_valid;
        state_d = (bus.in_valid && last_px) ? DRAIN : RUN;
      end
      default: state_d = drain_cnt ? IDLE : DRAIN;
    endcase
  end
  // window as it will look once the incoming pixel is shifted in; feeds the multipliers directly
  always_comb begin
    nwin[0] = win[1]; nwin[1] = win[2]; nwin[2] = lb2[col];
    nwin[3] = win[4]; nwin[4] = win[5]; nwin[5] = lb1[col];
    nwin[6] = win[7]; nwin[7] = win[8]; nwin[8] = bus.in_data;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      w_loaded <= 1'b0;
      wcnt <= '0;
      col <= '0;
      row <= '0;
      drain_cnt <= 1'b0;
      load_done_q <= 1'b0;
      for (int i = 0; i < NW; i++) wt[i] <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      load_done_q <= w_wr && last_w;
      drain_cnt <= state_q == DRAIN && !drain_cnt;
      if (w_wr) begin
        wt[wcnt] <= bus.w_data;
        wcnt <= last_w ? '0 : wcnt + 1'b1;
        w_loaded <= w_loaded | last_w;
      end
      if (px_acc) begin
        lb1[col] <= bus.in_data;
        lb2[col] <= lb1[col];
        for (int i = 0; i < 9; i++) win[i] <= nwin[i];
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? (last_px ? '0 : row + 1'b1) : row;
      end
    end
  end
  always_comb begin
    res = '0;
    for (int k = 0; k < N_KERN; k++) begin
      acc[k] = '0;
      for (int i = 0; i < 9; i++) acc[k] = acc[k] + AW'(prod[k][i]);
      sh[k] = acc[k] >>> SHIFT;
      sat[k] = sh[k] > MAXV ? MAXV[DATA_W-1:0] : sh[k] < MINV ? MINV[DATA_W-1:0] : sh[k][DATA_W-1:0];
`ifdef CONV_RELU_EN
      res[k*DATA_W +: DATA_W] = sat[k][DATA_W-1] ? '0 : sat[k];
`else
      res[k*DATA_W +: DATA_W] = sat[k];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      out_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      out_q <= '0;
      for (int k = 0; k < N_KERN; k++)
        for (int i = 0; i < 9; i++) prod[k][i] <= '0;
    end else begin
      v1 <= px_acc && row >= RW'(2) && col >= CW'(2);
      l1 <= px_acc && last_px;
      out_valid_q <= v1;
      frame_done_q <= v1 && l1;
      if (v1) out_q <= res;
      if (px_acc)
        for (int k = 0; k < N_KERN; k++)
          for (int i = 0; i < 9; i++) prod[k][i] <= $signed(PW'(wt[k*9+i])) * $signed(PW'(nwin[i]));
    end
  end
endmodule
